// File: rtl/vending_controller_if.sv
// Signal bundle between the vending controller and its neighbours: the
// coin/keypad front end on one side and product_selector on the other.
// The controller uses the slave view; the front end / bench uses master.
interface vending_controller_if;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_code;
  logic       cancel;
  logic [4:0] product_price;
  logic       product_dispense_done;
  logic [1:0] product_sel;
  logic       signal_product_selector;
  logic       product_dispense_en;
  logic [4:0] credit;
  logic       coin_reject;
  logic       insufficient;
  logic       change_valid;
  logic [4:0] change_amount;
  logic       busy;
  logic       fault;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_code, cancel,
           product_price, product_dispense_done,
    input  product_sel, signal_product_selector, product_dispense_en,
           credit, coin_reject, insufficient, change_valid, change_amount,
           busy, fault
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_code, cancel,
           product_price, product_dispense_done,
    output product_sel, signal_product_selector, product_dispense_en,
           credit, coin_reject, insufficient, change_valid, change_amount,
           busy, fault
  );
endinterface

// File: rtl/vending_controller.sv
// Vending machine sequencer: coin credit accumulation, product selection
// handshake with product_selector, price check, dispense supervision and
// change issue.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no credit; first accepted coin opens a transaction
// COLLECT  | accumulating credit; waits for selection or cancel
// LOOKUP   | one-cycle select pulse to product_selector
// CHECK    | compare returned price with credit, debit on success
// DISPENSE | dispense enable held; waits for done or timeout
// CHANGE   | one-cycle change pulse carrying remaining credit
// FAULT    | dispense timed out; sticky until reset, credit held
//
// coin_reject and insufficient are combinational pulses coincident with the
// strobe (or CHECK cycle) that caused them. CREDIT_MAX must not exceed 31.
module vending_controller #(
  parameter int DONE_TIMEOUT = 15,
  parameter int CREDIT_MAX   = 31
) (
  input logic              clk,
  input logic              rst_n,
  vending_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_LOOKUP   = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_DISPENSE = 3'd4;
  localparam logic [2:0] S_CHANGE   = 3'd5;
  localparam logic [2:0] S_FAULT    = 3'd6;

  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);
  localparam logic [5:0]    CMAX     = 6'(CREDIT_MAX);

  logic [2:0]    state_q, state_d;
  logic [4:0]    credit_q, credit_d;
  logic [1:0]    sel_q, sel_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [4:0] coin_units;
  logic       coin_hit;
  logic [5:0] coin_sum;
  logic       coin_fits;
  logic       price_ok;
  logic       coin_reject_c;
  logic       insufficient_c;

  // Decode the coin code and precompute the saturation and price checks.
  always_comb begin
    coin_units = 5'd0;
    case (bus.coin_value)
      2'b01:   coin_units = 5'd1;
      2'b10:   coin_units = 5'd2;
      2'b11:   coin_units = 5'd5;
      default: coin_units = 5'd0;
    endcase
    // A strobe carrying code 00 is not a coin at all: no credit, no reject.
    coin_hit  = bus.coin_valid && (bus.coin_value != 2'b00);
    // One extra bit so the overflow test cannot wrap.
    coin_sum  = {1'b0, credit_q} + {1'b0, coin_units};
    coin_fits = (coin_sum <= CMAX);
    price_ok  = (bus.product_price != 5'd0) && (bus.product_price <= credit_q);
  end

  // Next-state, credit, selection and timeout logic plus the refusal pulses.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    sel_d          = sel_q;
    tmo_d          = '0;
    coin_reject_c  = 1'b0;
    insufficient_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (coin_hit) begin
          if (coin_fits) begin
            credit_d = coin_sum[4:0];
            state_d  = S_COLLECT;
          end else begin
            coin_reject_c = 1'b1;
          end
        end
        // No credit yet, so any selection is refused outright.
        insufficient_c = bus.sel_valid;
      end
      S_COLLECT: begin
        if (bus.cancel) begin
          // Cancel wins; a coin arriving in the same cycle is handed back.
          coin_reject_c = coin_hit;
          state_d       = S_CHANGE;
        end else if (coin_hit) begin
          if (coin_fits) begin
            credit_d = coin_sum[4:0];
          end else begin
            coin_reject_c = 1'b1;
          end
        end else if (bus.sel_valid) begin
          sel_d   = bus.sel_code;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        coin_reject_c = coin_hit;
        state_d       = S_CHECK;
      end
      S_CHECK: begin
        coin_reject_c = coin_hit;
        if (price_ok) begin
          credit_d = credit_q - bus.product_price;
          state_d  = S_DISPENSE;
        end else begin
          insufficient_c = 1'b1;
          state_d        = S_COLLECT;
        end
      end
      S_DISPENSE: begin
        coin_reject_c = coin_hit;
        if (bus.product_dispense_done) begin
          state_d = (credit_q != 5'd0) ? S_CHANGE : S_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHANGE: begin
        coin_reject_c = coin_hit;
        credit_d      = 5'd0;
        state_d       = S_IDLE;
      end
      S_FAULT: begin
        coin_reject_c = coin_hit;
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = 5'd0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      credit_q <= 5'd0;
      sel_q    <= 2'b00;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.product_sel             = sel_q;
  assign bus.signal_product_selector = (state_q == S_LOOKUP);
  assign bus.product_dispense_en     = (state_q == S_DISPENSE);
  assign bus.credit                  = credit_q;
  assign bus.coin_reject             = coin_reject_c;
  assign bus.insufficient            = insufficient_c;
  assign bus.change_valid            = (state_q == S_CHANGE);
  assign bus.change_amount           = (state_q == S_CHANGE) ? credit_q : 5'd0;
  assign bus.busy                    = (state_q == S_LOOKUP) || (state_q == S_CHECK) ||
                                       (state_q == S_DISPENSE) || (state_q == S_CHANGE);
  assign bus.fault                   = (state_q == S_FAULT);

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_vending_controller;

  localparam int DONE_TIMEOUT = 15;
  localparam int CREDIT_MAX   = 31;

  logic clk;
  logic rst_n;
  vending_controller_if bus();

  vending_controller #(
    .DONE_TIMEOUT (DONE_TIMEOUT),
    .CREDIT_MAX   (CREDIT_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_COLLECT, M_LOOKUP, M_CHECK, M_DISP, M_CHANGE, M_FAULT} mph_t;

  int   n_vec;
  int   n_bad;
  mph_t mph;
  int   m_credit;
  int   m_sel;
  int   m_wait;
  int   price_tbl [4] = '{0, 10, 3, 7};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int coin_units(input logic [1:0] code);
    case (code)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 5;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mph      = M_IDLE;
    m_credit = 0;
    m_sel    = 0;
    m_wait   = 0;
  endtask

  task automatic zero_inputs();
    bus.coin_valid            = 1'b0;
    bus.coin_value            = 2'b00;
    bus.sel_valid             = 1'b0;
    bus.sel_code              = 2'b00;
    bus.cancel                = 1'b0;
    bus.product_price         = 5'd0;
    bus.product_dispense_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_credit"}, bus.credit, 0);
    chk({tag, "_sel"}, bus.product_sel, 0);
    chk({tag, "_select_pulse"}, bus.signal_product_selector, 0);
    chk({tag, "_dispense_en"}, bus.product_dispense_en, 0);
    chk({tag, "_change_valid"}, bus.change_valid, 0);
    chk({tag, "_change_amount"}, bus.change_amount, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_fault"}, bus.fault, 0);
    chk({tag, "_coin_reject"}, bus.coin_reject, 0);
    chk({tag, "_insufficient"}, bus.insufficient, 0);
  endtask

  // Entered and left at a falling edge.
  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Reset dropped between edges; outputs must clear without a clock.
  task automatic async_reset();
    zero_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance model.
  task automatic cyc(input logic cv, input logic [1:0] cval, input logic sv,
                     input logic [1:0] sc, input logic cn, input logic dn);
    int u;
    int price;
    bit e_rej;
    bit e_ins;
    bus.coin_valid            = cv;
    bus.coin_value            = cval;
    bus.sel_valid             = sv;
    bus.sel_code              = sc;
    bus.cancel                = cn;
    bus.product_dispense_done = dn;
    bus.product_price         = 5'(price_tbl[m_sel]);
    #1;
    u     = cv ? coin_units(cval) : 0;
    price = price_tbl[m_sel];
    e_rej = 1'b0;
    e_ins = 1'b0;
    case (mph)
      M_IDLE: begin
        e_rej = (u > 0) && (m_credit + u > CREDIT_MAX);
        e_ins = sv;
      end
      M_COLLECT: e_rej = (u > 0) && (cn || (m_credit + u > CREDIT_MAX));
      M_CHECK: begin
        e_rej = (u > 0);
        e_ins = (price == 0) || (price > m_credit);
      end
      default: e_rej = (u > 0);
    endcase

    chk("credit", bus.credit, m_credit);
    chk("product_sel", bus.product_sel, m_sel);
    chk("select_pulse", bus.signal_product_selector, mph == M_LOOKUP);
    chk("dispense_en", bus.product_dispense_en, mph == M_DISP);
    chk("change_valid", bus.change_valid, mph == M_CHANGE);
    chk("change_amount", bus.change_amount, (mph == M_CHANGE) ? m_credit : 0);
    chk("busy", bus.busy, mph inside {M_LOOKUP, M_CHECK, M_DISP, M_CHANGE});
    chk("fault", bus.fault, mph == M_FAULT);
    chk("coin_reject", bus.coin_reject, e_rej);
    chk("insufficient", bus.insufficient, e_ins);

    case (mph)
      M_IDLE: begin
        if (u > 0 && m_credit + u <= CREDIT_MAX) begin
          m_credit = u;
          mph      = M_COLLECT;
        end
      end
      M_COLLECT: begin
        if (cn) mph = M_CHANGE;
        else if (u > 0) begin
          if (m_credit + u <= CREDIT_MAX) m_credit += u;
        end else if (sv) begin
          m_sel = int'(sc);
          mph   = M_LOOKUP;
        end
      end
      M_LOOKUP: mph = M_CHECK;
      M_CHECK: begin
        if (price != 0 && price <= m_credit) begin
          m_credit -= price;
          m_wait    = 0;
          mph       = M_DISP;
        end else begin
          mph = M_COLLECT;
        end
      end
      M_DISP: begin
        if (dn) mph = (m_credit > 0) ? M_CHANGE : M_IDLE;
        else begin
          m_wait++;
          if (m_wait >= DONE_TIMEOUT) mph = M_FAULT;
        end
      end
      M_CHANGE: begin
        m_credit = 0;
        mph      = M_IDLE;
      end
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] code);
    cyc(1'b1, code, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic pick(input logic [1:0] code);
    cyc(1'b0, 2'b00, 1'b1, code, 1'b0, 1'b0);
  endtask

  task automatic done_cyc(input logic dn);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, dn);
  endtask

  initial begin
    int fcnt;
    n_vec = 0;
    n_bad = 0;
    fcnt  = 0;
    model_reset();
    zero_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Exact payment: 5+5, product 1 at price 10.
    coin(2'b11); coin(2'b11); pick(2'b01);
    idle(2);
    done_cyc(1'b0); done_cyc(1'b0); done_cyc(1'b1);
    chk("exact_credit", bus.credit, 0);
    chk("exact_no_change", bus.change_valid, 0);
    idle(2);

    // Overpay: 5+5+5 against price 10 leaves 5 in change.
    coin(2'b11); coin(2'b11); coin(2'b11); pick(2'b01);
    idle(2);
    done_cyc(1'b1);
    chk("overpay_change", bus.change_amount, 5);
    idle(2);

    // Insufficient: credit 2 against price 10, then cancel returns 2.
    coin(2'b10); pick(2'b01);
    idle(2);
    chk("insuff_credit", bus.credit, 2);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("insuff_refund", bus.change_amount, 2);
    idle(1);

    // Invalid product (price 0) is refused too.
    coin(2'b11); pick(2'b00);
    idle(2);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(1);

    // Saturation at 30, reject 2, accept 1 to reach 31.
    for (int i = 0; i < 6; i++) coin(2'b11);
    chk("sat_30", bus.credit, 30);
    coin(2'b10);
    chk("sat_hold", bus.credit, 30);
    coin(2'b01);
    chk("sat_31", bus.credit, 31);
    cyc(1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    idle(1);

    // Simultaneous cancel + coin + select: cancel wins, coin refused.
    coin(2'b11); coin(2'b10);
    cyc(1'b1, 2'b11, 1'b1, 2'b01, 1'b1, 1'b0);
    chk("simul_change", bus.change_amount, 7);
    idle(1);

    // Timeout into FAULT; coins refused there; reset clears it.
    coin(2'b11); coin(2'b11); pick(2'b10);
    idle(2);
    for (int i = 0; i < DONE_TIMEOUT; i++) done_cyc(1'b0);
    chk("tmo_fault", bus.fault, 1);
    chk("tmo_en_low", bus.product_dispense_en, 0);
    coin(2'b01);
    idle(2);
    do_reset();

    // Asynchronous reset in the middle of DISPENSE.
    coin(2'b11); coin(2'b11); pick(2'b01);
    idle(2);
    done_cyc(1'b0); done_cyc(1'b0);
    async_reset();
    idle(1);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic       cv, sv, cn, dn;
      logic [1:0] cval, sc;
      cv   = ($urandom_range(0, 3) == 0);
      cval = 2'($urandom_range(0, 3));
      sv   = ($urandom_range(0, 5) == 0);
      sc   = 2'($urandom_range(0, 3));
      cn   = ($urandom_range(0, 19) == 0);
      dn   = ($urandom_range(0, 2) == 0);
      cyc(cv, cval, sv, sc, cn, dn);
      if (mph == M_FAULT) begin
        fcnt++;
        if (fcnt > 3) begin
          do_reset();
          fcnt = 0;
        end
      end
      if ($urandom_range(0, 399) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
